// File: rtl/eye_tracker_if.sv
// Camera input and VGA output bundle shared by the eye tracker and its environment.
// master drives the camera side and observes video; slave is the tracker's view.
interface eye_tracker_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   cclk;
  logic                   fval;
  logic                   lval;
  logic                   dval;
  logic [PIXEL_WIDTH-1:0] data_l;
  logic [PIXEL_WIDTH-1:0] data_r;
  logic                   vga_clk;
  logic                   hsync;
  logic                   vsync;
  logic [PIXEL_WIDTH-1:0] r;
  logic [PIXEL_WIDTH-1:0] g;
  logic [PIXEL_WIDTH-1:0] b;

  modport master (
    output cclk, fval, lval, dval, data_l, data_r,
    input  vga_clk, hsync, vsync, r, g, b
  );

  modport slave (
    input  cclk, fval, lval, dval, data_l, data_r,
    output vga_clk, hsync, vsync, r, g, b
  );
endinterface

// File: rtl/eye_tracker_top.sv
// Captures one camera line into a line buffer and replays it, horizontally doubled,
// on a free-running 640x480 VGA raster with a red highlight for dark pixels.
module eye_tracker_top #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int PIX_HACT    = 640
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   UART_RXD,
  output logic                   UART_TXD,
  input  logic [7:0]             JP,
  input  logic                   CCLK,
  input  logic                   FVAL,
  input  logic                   LVAL,
  input  logic                   DVAL,
  input  logic [PIXEL_WIDTH-1:0] DATA_L,
  input  logic [PIXEL_WIDTH-1:0] DATA_R,
  output logic                   VGA_CLK,
  output logic                   VGA_HSYNC,
  output logic                   VGA_VSYNC,
  output logic [PIXEL_WIDTH-1:0] VGA_R,
  output logic [PIXEL_WIDTH-1:0] VGA_G,
  output logic [PIXEL_WIDTH-1:0] VGA_B
);

  localparam int SW = 4 + 2 * PIXEL_WIDTH;
  localparam logic [9:0] HACT     = 10'(PIX_HACT);
  localparam logic [9:0] HS_START = 10'(PIX_HACT + 16);
  localparam logic [9:0] HS_END   = 10'(PIX_HACT + 111);

  logic                   unused_rxd;
  assign unused_rxd = UART_RXD;
  assign UART_TXD   = 1'b1;

  // camera capture side
  logic [SW-1:0]          meta_q, sync_q;
  logic                   s_cclk, s_fval, s_lval, s_dval;
  logic [PIXEL_WIDTH-1:0] s_dl, s_dr;
  logic                   cclk_prev_q, lval_prev_q, lval_prev_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d, wr_addr;
  logic                   sample, lval_rise, wr_en;
  logic [PIXEL_WIDTH-1:0] wr_pix;

  assign {s_cclk, s_fval, s_lval, s_dval, s_dl, s_dr} = sync_q;

  always_comb begin
    sample      = s_cclk & ~cclk_prev_q;
    lval_rise   = s_lval & ~lval_prev_q;
    wr_en       = sample & s_fval & s_dval;
    wr_pix      = JP[7] ? s_dr : s_dl;
    wr_addr     = (sample && lval_rise) ? '0 : waddr_q;
    waddr_d     = waddr_q;
    lval_prev_d = lval_prev_q;
    if (sample) begin
      lval_prev_d = s_lval;
      waddr_d     = wr_addr;
      // the last location absorbs every sample beyond the buffer depth
      if (wr_en && (wr_addr != '1)) waddr_d = wr_addr + ADDR_WIDTH'(1);
    end
  end

  // display side
  logic                   vga_clk_q, pix_en;
  logic [9:0]             hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [PIXEL_WIDTH-1:0] rd_data_q;
  logic                   act1_q, hs1_q, vs1_q, act_d, hs_d, vs_d;
  logic                   hs_q, vs_q;
  logic [PIXEL_WIDTH-1:0] r_q, g_q, b_q, r_d, g_d, b_d, thr;

  assign pix_en  = ~vga_clk_q;
  assign rd_addr = ADDR_WIDTH'(hcnt_q >> 1);
  assign thr     = PIXEL_WIDTH'({JP[6:0], 1'b0});

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == 10'd799) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == 10'd524) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    act_d = (hcnt_q < HACT) && (vcnt_q < 10'd480);
    hs_d  = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
    vs_d  = !((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491));
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    if (act1_q) begin
      if ((JP[6:0] != 7'd0) && (rd_data_q < thr)) begin
        r_d = '1;
      end else begin
        r_d = rd_data_q;
        g_d = rd_data_q;
        b_d = rd_data_q;
      end
    end
  end

  // line buffer: contents survive reset; read-before-write gives old data on a collision
  logic [PIXEL_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge CLK) begin
    if (wr_en)  mem_q[wr_addr] <= wr_pix;
    if (pix_en) rd_data_q      <= mem_q[rd_addr];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q      <= '0;
      sync_q      <= '0;
      cclk_prev_q <= 1'b0;
      lval_prev_q <= 1'b0;
      waddr_q     <= '0;
      vga_clk_q   <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      act1_q      <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      meta_q      <= {CCLK, FVAL, LVAL, DVAL, DATA_L, DATA_R};
      sync_q      <= meta_q;
      cclk_prev_q <= s_cclk;
      lval_prev_q <= lval_prev_d;
      waddr_q     <= waddr_d;
      vga_clk_q   <= ~vga_clk_q;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      // two-stage video pipeline: timing flags ride alongside the buffer read
      if (pix_en) begin
        act1_q <= act_d;
        hs1_q  <= hs_d;
        vs1_q  <= vs_d;
        hs_q   <= hs1_q;
        vs_q   <= vs1_q;
        r_q    <= r_d;
        g_q    <= g_d;
        b_q    <= b_d;
      end
    end
  end

  assign VGA_CLK   = vga_clk_q;
  assign VGA_HSYNC = hs_q;
  assign VGA_VSYNC = vs_q;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;

endmodule

// File: tb/tb_eye_tracker_top.sv
// Directed bench for eye_tracker_top: raster timing, capture, threshold and reset behaviour.
module tb_eye_tracker_top;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] jp;
  int         total;
  int         bad;
  int         cur_j;

  eye_tracker_if #(.PIXEL_WIDTH(8)) vif ();

  eye_tracker_top #(.PIXEL_WIDTH(8), .ADDR_WIDTH(9), .PIX_HACT(640)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .UART_RXD  (uart_rxd),
    .UART_TXD  (uart_txd),
    .JP        (jp),
    .CCLK      (vif.cclk),
    .FVAL      (vif.fval),
    .LVAL      (vif.lval),
    .DVAL      (vif.dval),
    .DATA_L    (vif.data_l),
    .DATA_R    (vif.data_r),
    .VGA_CLK   (vif.vga_clk),
    .VGA_HSYNC (vif.hsync),
    .VGA_VSYNC (vif.vsync),
    .VGA_R     (vif.r),
    .VGA_G     (vif.g),
    .VGA_B     (vif.b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // camera driver: one CCLK period of 4 CLK, data stable across the rising edge
  task automatic cam_pulse();
    vif.cclk = 1'b0;
    repeat (2) @(negedge clk);
    vif.cclk = 1'b1;
    repeat (2) @(negedge clk);
    vif.cclk = 1'b0;
  endtask

  task automatic cam_gap();
    vif.lval = 1'b0;
    vif.dval = 1'b0;
    cam_pulse();
  endtask

  task automatic cam_pix(input logic [7:0] dl, input logic [7:0] dr);
    vif.data_l = dl;
    vif.data_r = dr;
    vif.lval   = 1'b1;
    vif.dval   = 1'b1;
    cam_pulse();
  endtask

  // video monitor: align to HSYNC fall (pixel 656), then walk to pixel h of the next line
  task automatic sync_line();
    logic prev;
    logic found;
    found = 1'b0;
    prev  = vif.hsync;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      if (prev && !vif.hsync) begin
        found = 1'b1;
        break;
      end
      prev = vif.hsync;
    end
    if (!found) chk("hsync_timeout", 32'd0, 32'd1);
    cur_j = 0;
  endtask

  task automatic pix_at(input string tag, input int h, input logic [23:0] exp);
    int target;
    target = 2 * (h + 144);
    while (cur_j < target) begin
      @(negedge clk);
      cur_j++;
    end
    chk(tag, {8'h00, vif.r, vif.g, vif.b}, {8'h00, exp});
  endtask

  task automatic count_to_hsync_fall(output int n);
    n = 0;
    for (int i = 1; i <= 3300; i++) begin
      @(negedge clk);
      if (!vif.hsync) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int          n;
    int          low_w;
    int          per;
    logic        seen_high;
    logic        v1;
    logic [7:0]  d;
    total      = 0;
    bad        = 0;
    cur_j      = 0;
    rst_n      = 1'b0;
    uart_rxd   = 1'b1;
    jp         = 8'h00;
    vif.cclk   = 1'b0;
    vif.fval   = 1'b1;
    vif.lval   = 1'b0;
    vif.dval   = 1'b0;
    vif.data_l = 8'h00;
    vif.data_r = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_vga_clk", {31'd0, vif.vga_clk}, 32'd0);
    chk("rst_hsync", {31'd0, vif.hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vif.vsync}, 32'd1);
    chk("rst_rgb", {8'h00, vif.r, vif.g, vif.b}, 32'd0);
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);

    rst_n = 1'b1;
    count_to_hsync_fall(n);
    chk("hs_first_fall", n, 1315);

    // HSYNC low width and period
    low_w = 0;
    per = 0;
    seen_high = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (!seen_high && vif.hsync) begin
        low_w = i;
        seen_high = 1'b1;
      end
      if (seen_high && !vif.hsync) begin
        per = i;
        break;
      end
    end
    chk("hs_low_width", low_w, 192);
    chk("hs_period", per, 1600);
    chk("vsync_idle", {31'd0, vif.vsync}, 32'd1);
    chk("txd_idle", {31'd0, uart_txd}, 32'd1);
    v1 = vif.vga_clk;
    @(negedge clk);
    chk("vga_clk_toggle", {31'd0, v1 ^ vif.vga_clk}, 32'd1);

    // line 1: left camera ramp, no threshold
    jp = 8'h00;
    cam_gap();
    for (int k = 0; k < 320; k++) cam_pix(8'(k), 8'h00);
    cam_gap();
    sync_line();
    pix_at("l1_p0", 0, 24'h000000);
    pix_at("l1_p2", 2, 24'h010101);
    pix_at("l1_p3", 3, 24'h010101);
    pix_at("l1_p200", 200, 24'h646464);
    pix_at("l1_p201", 201, 24'h646464);
    pix_at("l1_p511", 511, 24'hFFFFFF);
    pix_at("l1_p600", 600, 24'h2C2C2C);
    pix_at("l1_p639", 639, 24'h3F3F3F);
    pix_at("l1_blank", 640, 24'h000000);

    // threshold T=10 against the same buffer
    jp = 8'h05;
    sync_line();
    pix_at("thr_p18_red", 18, 24'hFF0000);
    pix_at("thr_p19_red", 19, 24'hFF0000);
    pix_at("thr_p20_gray", 20, 24'h0A0A0A);

    // line 2: right camera selected, offset ramp
    jp = 8'h80;
    cam_gap();
    for (int k = 0; k < 320; k++) cam_pix(8'h55, 8'(k + 16));
    cam_gap();
    sync_line();
    pix_at("l2_p0", 0, 24'h101010);
    pix_at("l2_p200", 200, 24'h747474);
    pix_at("l2_p481", 481, 24'h000000);
    pix_at("l2_p500", 500, 24'h0A0A0A);

    // line 3: threshold edge at T=0xFE
    jp = 8'h7F;
    cam_gap();
    cam_pix(8'hFD, 8'h00);
    cam_pix(8'hFE, 8'h00);
    cam_gap();
    sync_line();
    pix_at("l3_p0_red", 0, 24'hFF0000);
    pix_at("l3_p1_red", 1, 24'hFF0000);
    pix_at("l3_p2_gray", 2, 24'hFEFEFE);
    pix_at("l3_p3_gray", 3, 24'hFEFEFE);
    pix_at("l3_p4_old_red", 4, 24'hFF0000);

    // line 4: 600 samples, overflow must not wrap to address 0
    jp = 8'h00;
    cam_gap();
    for (int k = 0; k < 600; k++) begin
      d = (k < 512) ? 8'(k) : 8'hEE;
      cam_pix(d, 8'h00);
    end
    cam_gap();
    sync_line();
    pix_at("sat_p0", 0, 24'h000000);
    pix_at("sat_p100", 100, 24'h323232);
    pix_at("sat_p639", 639, 24'h3F3F3F);

    // FVAL low: no writes
    vif.fval = 1'b0;
    cam_gap();
    for (int k = 0; k < 8; k++) cam_pix(8'h77, 8'h77);
    cam_gap();
    vif.fval = 1'b1;
    sync_line();
    pix_at("nofval_p0", 0, 24'h000000);
    pix_at("nofval_p10", 10, 24'h050505);

    // reset asserted in the middle of a captured line
    cam_gap();
    for (int k = 0; k < 10; k++) cam_pix(8'hC0 + 8'(k), 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_vga_clk", {31'd0, vif.vga_clk}, 32'd0);
    chk("mid_rst_hsync", {31'd0, vif.hsync}, 32'd1);
    chk("mid_rst_vsync", {31'd0, vif.vsync}, 32'd1);
    chk("mid_rst_rgb", {8'h00, vif.r, vif.g, vif.b}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_to_hsync_fall(n);
    chk("mid_rst_hs_fall", n, 1315);
    cam_gap();
    for (int k = 0; k < 4; k++) cam_pix(8'hA0 + 8'(k), 8'h00);
    cam_gap();
    sync_line();
    pix_at("post_rst_p0", 0, 24'hA0A0A0);
    pix_at("post_rst_p6", 6, 24'hA3A3A3);
    pix_at("post_rst_p8_kept", 8, 24'hC4C4C4);
    pix_at("post_rst_p40_kept", 40, 24'h141414);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eye_tracker_top.md
EYE_TRACKER_TOP -- requirements
Module: eye_tracker_top

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8; camera and VGA colour sample width.
REQ-002 Parameter ADDR_WIDTH, default 9; line-buffer address width, depth 2^ADDR_WIDTH.
REQ-003 Parameter PIX_HACT, default 640; VGA active pixels per line.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: CLK is the only clock, RST_N is the reset.
REQ-005 CLK  in  1  system clock, 50 MHz.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 UART_RXD  in  1  ignored.
REQ-008 UART_TXD  out  1  constant 1 (idle).
REQ-009 JP  in  8  jumper settings: JP[7] camera select (0=left, 1=right); JP[6:0] threshold code.
REQ-010 CCLK  in  1  camera pixel clock; treated as data, sampled on CLK.
REQ-011 FVAL, LVAL, DVAL  in  1 each  camera frame valid, line valid, data valid.
REQ-012 DATA_L, DATA_R  in  PIXEL_WIDTH each  left/right camera pixel.
REQ-013 VGA_CLK  out  1  pixel clock, CLK/2.
REQ-014 VGA_HSYNC, VGA_VSYNC  out  1 each  active-low syncs.
REQ-015 VGA_R, VGA_G, VGA_B  out  PIXEL_WIDTH each  colour.

Function
REQ-016 CCLK, FVAL, LVAL, DVAL, DATA_L, DATA_R SHALL pass through a 2-flop CLK synchronizer; a camera sample SHALL be taken on the CLK cycle where synchronized CCLK is 1 and its previous value was 0; CCLK frequency SHALL be at most CLK/2.5.
REQ-017 Camera pixel = DATA_R if JP[7]=1, else DATA_L, using the synchronized values at the sample point.
REQ-018 Write address SHALL reset to 0 at each sampled LVAL 0->1, and SHALL increment by 1 after each sample with DVAL=1 and FVAL=1, saturating at 2^ADDR_WIDTH-1.
REQ-019 The selected pixel SHALL be written to a dual-port line buffer at the write address on each sample with DVAL=1 and FVAL=1; no write otherwise.
REQ-020 VGA_CLK SHALL toggle every CLK cycle; pixel enable is the CLK cycle where VGA_CLK goes 0->1.
REQ-021 On each pixel enable, hcnt SHALL count 0..799 and wrap; on hcnt wrap, vcnt SHALL count 0..524 and wrap.
REQ-022 Active video: hcnt < PIX_HACT and vcnt < 480.
REQ-023 VGA_HSYNC = 0 for hcnt in [PIX_HACT+16, PIX_HACT+111], else 1.
REQ-024 VGA_VSYNC = 0 for vcnt in [490, 491], else 1.
REQ-025 Read address = hcnt >> 1 (horizontal doubling).
REQ-026 Threshold T = {JP[6:0], 1'b0}.
REQ-027 Active pixel p: if JP[6:0] != 0 and p < T, RGB = (FF, 00, 00); otherwise RGB = (p, p, p).
REQ-028 Blanking: RGB = 0.
REQ-029 Syncs and RGB SHALL be registered and aligned to the same pixel; total latency from hcnt to output is 2 pixel enables.
REQ-030 A simultaneous read and write to the same address SHALL return the old data.
REQ-031 The display SHALL be free-running and not locked to FVAL; tearing is acceptable.

Reset
REQ-032 While RST_N=0: hcnt=vcnt=0, write address=0, VGA_CLK=0, VGA_HSYNC=VGA_VSYNC=1, RGB=0, UART_TXD=1, synchronizers cleared.
REQ-033 Line-buffer contents are not reset.
REQ-034 Reset SHALL act immediately; assertion mid-frame SHALL abort capture and scan, which restart from 0 after release.

Verification
REQ-035 Reset released, no camera activity -> VGA_HSYNC period 1600 CLK with low width 192 CLK; VGA_VSYNC low for 2 lines every 525 lines; UART_TXD=1.
REQ-036 CCLK 20 MHz, one line with LVAL=DVAL=FVAL=1, DATA_L=0..319, JP=0x00 -> buffer[k]=k; VGA active pixels 2k and 2k+1 show (k,k,k) for k<256.
REQ-037 Same line with JP=0x80 and DATA_R=k+16 -> VGA pixel pair k shows gray (k+16)&255.
REQ-038 JP=0x7F (T=0xFE), DATA_L=0xFD then 0xFE -> first pixel red (FF,00,00), second gray (FE,FE,FE).
REQ-039 600 samples in one line -> write address saturates at 511 and only buffer[511] is rewritten; FVAL=0 with DVAL=1 -> no write.
REQ-040 RST_N pulsed low mid-line -> outputs reach reset values immediately; a new LVAL rise restarts writes at address 0.
